flag_register_unit: RTL
=======================

Name: flag_register_unit

Overview:
- Condition-code register (CCR) that sits on the consumer side of the ALU flag interface.
- Captures the {V,Z,N,C} flags the execute stage produces and feeds the architectural flags back to the ALU flag inputs on the next cycle.
- Saves and restores flags across interrupt entry and RTI using a bounded LIFO shadow stack.
- Also provides a same-cycle forwarded flag value for the branch-resolution logic.

Parameters:
- STACK_DEPTH, 4: maximum interrupt nesting depth, i.e. number of shadow flag entries.
- FLAG_W, 4: flag vector width. Bit order is [3]=V, [2]=Z, [1]=N, [0]=C. Fixed at 4; exists as a parameter only for the package constant.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  pipeline stall; freezes all state.
- aluFlagsIn  in  FLAG_W  flags from ALU for the instruction leaving execute.
- flagWrite  in  1  aluFlagsIn is valid and must be committed this cycle.
- intEnter  in  1  interrupt accepted; push flags onto shadow stack.
- rtiPop  in  1  RTI executing; restore flags from shadow stack.
- errClear  in  1  clears sticky error bits.
- flagsOut  out  FLAG_W  registered architectural flags, wired to the ALU flag inputs.
- flagsFwd  out  FLAG_W  combinational next-state flags, for branch forwarding.
- stackDepth  out  $clog2(STACK_DEPTH+1)  number of valid shadow entries.
- stackOverflow  out  1  sticky: a push was attempted while full.
- stackUnderflow  out  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (rst=0, asynchronous): flagsOut=0, all stack entries=0, stackDepth=0, both sticky bits=0. Outputs read 0 from assertion until the first rising edge after deassertion. Reset mid-push or mid-pop discards the operation.
- Latency: a flag update committed at edge k is visible on flagsOut after edge k. flagsFwd shows the same value combinationally during the cycle before edge k.
- stall=1: no state changes. flagsFwd=flagsOut. Sticky bits hold. errClear is ignored.
- Next-flag selection when stall=0, in priority order:
  - rtiPop with stackDepth>0 and intEnter=0: next=stack top. flagWrite is ignored, because the restore wins.
  - otherwise flagWrite=1: next=aluFlagsIn.
  - otherwise: next=flagsOut.
- flagsFwd always equals the next value.
- Push (intEnter=1, stall=0):
  - The pushed value is the next value after flagWrite is applied, so a completing instruction retires before the interrupt.
  - stackDepth increments.
  - flagsOut takes the next value; interrupt entry does not clear flags.
- Push when full (stackDepth==STACK_DEPTH): the stack is unchanged and stackDepth is unchanged. stackOverflow<=1. The flagsOut update still happens.
- Pop (rtiPop=1, intEnter=0, stall=0, depth>0): flagsOut<=top entry, stackDepth decrements. The vacated entry need not be cleared.
- Pop when empty: flagsOut follows the normal flagWrite/hold rule and stackDepth stays 0. stackUnderflow<=1.
- intEnter and rtiPop asserted together: the push is performed and the pop is ignored. No error is flagged for the ignored pop.
- Sticky bits:
  - errClear=1 clears both.
  - A new error event in the same cycle wins over errClear, so the bit sets.
- Depth wrap-around is forbidden. stackDepth saturates at 0 and at STACK_DEPTH.
- No combinational path from any input to flagsOut.
- flagsFwd is combinational from aluFlagsIn, flagWrite, intEnter, rtiPop and stall, plus state.

Decomposition:
- Shared package (the existing defines file) holds:
  - FLAG_W and the bit indices FLAG_V=3, FLAG_Z=2, FLAG_N=1, FLAG_C=0, which the ALU also uses.
  - the default STACK_DEPTH.
- One sub-module, flag_stack: a parameterised LIFO with push, pop, top, depth, full and empty, and reset to empty.
- Priority logic, the flags register and the sticky bits live in the top level.

Test Plan:
- Reset, then flagWrite=1, aluFlagsIn=4'b0101 -> flagsFwd=0101 in the same cycle; flagsOut=0101 after the edge; stackDepth=0.
- flagsOut=0101; intEnter=1 with flagWrite=1, aluFlagsIn=4'b1000 -> top=1000, depth=1, flagsOut=1000. Then flagWrite=0010 -> flagsOut=0010. Then rtiPop with flagWrite=1111 -> flagsOut=1000, depth=0.
- STACK_DEPTH=4:
  - push 5 times with distinct flags 0001..0101 -> depth=4, stackOverflow=1 after the 5th.
  - then 4 pops -> flagsOut=0100, 0011, 0010, 0001 in order.
  - a 5th pop -> stackUnderflow=1, flagsOut unchanged.
- intEnter and rtiPop together at depth=2 -> depth=3, no underflow. With stall=1 held for 3 cycles under any stimulus -> all outputs frozen.
- Sticky bits set; errClear=1 alone -> both 0. errClear=1 with a pop on empty in the same cycle -> stackUnderflow=1.
- Assert rst=0 between clock edges during a push sequence at depth=2 -> flagsOut=0 and depth=0 immediately. After release, the first pop -> underflow=1.

Source files
------------

// File: rtl/flag_register_unit_pkg.sv
// Shared flag definitions for the ALU and the condition-code register.
//   FLAG_W               width of the {V,Z,N,C} flag vector
//   FLAG_V/Z/N/C         bit positions inside the flag vector
//   STACK_DEPTH_DEFAULT  default interrupt nesting depth of the shadow stack
package flag_register_unit_pkg;

    localparam int FLAG_W = 4;

    localparam int FLAG_V = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 0;

    localparam int STACK_DEPTH_DEFAULT = 4;

    typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/flag_register_unit_flag_stack.sv
// Bounded LIFO holding shadow copies of the flags across interrupt nesting.
//   clk, rst      clock, asynchronous active-low reset (stack becomes empty)
//   push, pop     push pushData / drop the top entry; push has priority
//   pushData      value written on push
//   topData       current top entry (0 while empty)
//   depth         number of valid entries, 0..DEPTH
//   full, empty   depth == DEPTH / depth == 0
// A push while full and a pop while empty are silently ignored; the caller
// is responsible for reporting those as errors.
module flag_stack
    import flag_register_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             pushData,
    output logic [WIDTH-1:0]             topData,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         full,
    output logic                         empty
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] entries [DEPTH];
    logic [DW-1:0]    topIdx;

    assign full   = (depth == DW'(DEPTH));
    assign empty  = (depth == '0);
    assign topIdx = depth - DW'(1);

    // topIdx wraps when empty, so the read is masked rather than trusted.
    assign topData = empty ? '0 : entries[topIdx[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            depth <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (push && !full) begin
            entries[depth[AW-1:0]] <= pushData;
            depth                  <= depth + DW'(1);
        end else if (pop && !empty) begin
            depth <= depth - DW'(1);
        end
    end

endmodule

// File: rtl/flag_register_unit.sv
// Condition-code register on the consumer side of the ALU flag interface.
// Commits ALU flags, saves/restores them across interrupt entry and RTI
// through a bounded shadow stack, and forwards the next-state flags
// combinationally for branch resolution.
//   clk, rst        clock, asynchronous active-low reset
//   stall           freezes all state; flagsFwd then equals flagsOut
//   aluFlagsIn      {V,Z,N,C} from the instruction leaving execute
//   flagWrite       commit aluFlagsIn this cycle
//   intEnter        interrupt accepted: push the post-commit flags
//   rtiPop          RTI: restore flags from the stack top
//   errClear        clear both sticky error bits
//   flagsOut        registered architectural flags (to the ALU)
//   flagsFwd        combinational next-state flags
//   stackDepth      valid shadow entries
//   stackOverflow   sticky: push attempted while full
//   stackUnderflow  sticky: pop attempted while empty
module flag_register_unit #(
    parameter int STACK_DEPTH = flag_register_unit_pkg::STACK_DEPTH_DEFAULT,
    parameter int FLAG_W      = flag_register_unit_pkg::FLAG_W
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               stall,
    input  logic [FLAG_W-1:0]                  aluFlagsIn,
    input  logic                               flagWrite,
    input  logic                               intEnter,
    input  logic                               rtiPop,
    input  logic                               errClear,
    output logic [FLAG_W-1:0]                  flagsOut,
    output logic [FLAG_W-1:0]                  flagsFwd,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stackDepth,
    output logic                               stackOverflow,
    output logic                               stackUnderflow
);

    import flag_register_unit_pkg::*;

    logic [FLAG_W-1:0] flagsNext;
    logic [FLAG_W-1:0] stackTop;
    logic              stackFull;
    logic              stackEmpty;
    logic              doPush;
    logic              doPop;
    logic              ovfEvent;
    logic              unfEvent;

    // A simultaneous intEnter wins over rtiPop, and the dropped pop is not
    // an error. The pushed value is flagsNext, so a retiring instruction's
    // flags are saved before the handler runs.
    always_comb begin
        doPush    = !stall && intEnter;
        doPop     = !stall && rtiPop && !intEnter && !stackEmpty;
        ovfEvent  = doPush && stackFull;
        unfEvent  = !stall && rtiPop && !intEnter && stackEmpty;
        flagsNext = flagsOut;
        if (doPop) begin
            flagsNext = stackTop;
        end else if (!stall && flagWrite) begin
            flagsNext = aluFlagsIn;
        end
    end

    assign flagsFwd = flagsNext;

    flag_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (FLAG_W)
    ) uStack (
        .clk      (clk),
        .rst      (rst),
        .push     (doPush),
        .pop      (doPop),
        .pushData (flagsNext),
        .topData  (stackTop),
        .depth    (stackDepth),
        .full     (stackFull),
        .empty    (stackEmpty)
    );

    // A fresh error event outranks errClear in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flagsOut       <= '0;
            stackOverflow  <= 1'b0;
            stackUnderflow <= 1'b0;
        end else if (!stall) begin
            flagsOut       <= flagsNext;
            stackOverflow  <= ovfEvent || (stackOverflow && !errClear);
            stackUnderflow <= unfEvent || (stackUnderflow && !errClear);
        end
    end

endmodule
